// File: rtl/local_mem_pixel_buf_pkg.sv
// ---------------------------------------------------------------------------
// pixel_mem_pkg
// Shared types and constants for the local pixel buffer.
//   state_t        : controller state (IDLE / LOAD / CLEAR)
//   CH_RED..BLUE   : channel index constants (ch0 = red, ascending)
//   DEFAULT_DATA_W : default sample width
// ---------------------------------------------------------------------------
package pixel_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int CH_RED   = 0;
    localparam int CH_GREEN = 1;
    localparam int CH_BLUE  = 2;

    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/local_mem_pixel_buf_raster_cnt.sv
// ---------------------------------------------------------------------------
// pixel_raster_cnt
// Channel-planar raster counter: col fastest, then row, then channel.
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : advance one position
//   clr       : return to (0,0,0); takes priority over inc
//   ch/row/col: current position
//   last_pix  : row and col at their maxima (last pixel of a plane)
//   last      : last_pix on the final channel (last beat overall)
// After the final beat all fields return to zero.
// ---------------------------------------------------------------------------
module pixel_raster_cnt #(
    parameter int N_CH  = 3,
    parameter int ROW_W = 5,
    parameter int COL_W = 5,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CH_W-1:0]  ch,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_pix,
    output logic             last
);

    assign last_pix = (&row) && (&col);
    assign last     = last_pix && (ch == CH_W'(N_CH - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch  <= '0;
            row <= '0;
            col <= '0;
        end else if (clr || (inc && last)) begin
            ch  <= '0;
            row <= '0;
            col <= '0;
        end else if (inc) begin
            // H and W are powers of two, so row/col wrap by plain overflow.
            col <= col + 1'b1;
            if (&col) begin
                row <= row + 1'b1;
                if (&row)
                    ch <= ch + 1'b1;
            end
        end
    end

endmodule

// File: rtl/local_mem_pixel_buf.sv
// ---------------------------------------------------------------------------
// local_mem_pixel_buf
// On-chip H x W x CH pixel buffer for the convolution front end.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_*                : single-sample write (IDLE only, wr_ch >= CH dropped)
//   ld_start/valid/data : channel-planar raster bulk load, ld_ready/ld_done
//   clr_start           : zero every pixel, one pixel per cycle
//   busy                : LOAD or CLEAR in progress
//   rd_en/row/col       : signed coordinates, out of range reads return 0
//   rd_valid/rd_data    : 1-cycle latency, all channels, ch0 in the LSBs
// ---------------------------------------------------------------------------
module local_mem_pixel_buf
    import pixel_mem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CH     = CH_BLUE + 1,
    parameter int ROW_W  = 5,
    parameter int COL_W  = 5,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [ROW_W-1:0]     wr_row,
    input  logic [COL_W-1:0]     wr_col,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 ld_start,
    input  logic                 ld_valid,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ready,
    output logic                 ld_done,
    input  logic                 clr_start,
    output logic                 busy,
    input  logic                 rd_en,
    input  logic [ROW_W:0]       rd_row,
    input  logic [COL_W:0]       rd_col,
    output logic                 rd_valid,
    output logic [CH*DATA_W-1:0] rd_data
);

    localparam int ADDR_W = ROW_W + COL_W;
    localparam int NPIX   = 1 << ADDR_W;

    state_t state, state_next;

    logic [CH_W-1:0]  cnt_ch;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic             cnt_last_pix, cnt_last;
    logic             cnt_inc, cnt_clr;
    logic             ld_beat;

    logic                 pix_we;
    logic [ADDR_W-1:0]    pix_addr;
    logic [CH-1:0]        pix_mask;
    logic [CH*DATA_W-1:0] pix_wdata;
    logic [CH_W-1:0]      pix_ch;

    logic [CH*DATA_W-1:0] mem [NPIX];

    logic                 rd_in_range;
    logic [ADDR_W-1:0]    rd_addr;

    assign ld_beat = (state == LOAD) && ld_valid;
    assign cnt_inc = ld_beat || (state == CLEAR);
    // Holding the counter clear in IDLE guarantees every LOAD/CLEAR starts at 0.
    assign cnt_clr = (state == IDLE) || ((state == CLEAR) && cnt_last_pix);

    pixel_raster_cnt #(
        .N_CH  (CH),
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .CH_W  (CH_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .ch       (cnt_ch),
        .row      (cnt_row),
        .col      (cnt_col),
        .last_pix (cnt_last_pix),
        .last     (cnt_last)
    );

    // ---------------- controller ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != IDLE);
            ld_ready <= (state_next == LOAD);
            ld_done  <= ld_beat && cnt_last;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clr_start)
                    state_next = CLEAR;
                else if (ld_start)
                    state_next = LOAD;
            end
            LOAD:    if (ld_beat && cnt_last) state_next = IDLE;
            CLEAR:   if (cnt_last_pix)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- write port mux ----------------
    always_comb begin
        pix_we    = 1'b0;
        pix_addr  = '0;
        pix_ch    = '0;
        pix_mask  = '0;
        pix_wdata = '0;
        case (state)
            IDLE: begin
                if (wr_en && (int'(wr_ch) < CH)) begin
                    pix_we    = 1'b1;
                    pix_addr  = {wr_row, wr_col};
                    pix_ch    = wr_ch;
                    pix_wdata = {CH{wr_data}};
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    pix_we    = 1'b1;
                    pix_addr  = {cnt_row, cnt_col};
                    pix_ch    = cnt_ch;
                    pix_wdata = {CH{ld_data}};
                end
            end
            CLEAR: begin
                pix_we   = 1'b1;
                pix_addr = {cnt_row, cnt_col};
            end
            default: ;
        endcase
        for (int c = 0; c < CH; c++)
            pix_mask[c] = (state == CLEAR) || (pix_ch == CH_W'(c));
    end

    // NOTE: the storage has an asynchronous reset because a reset must leave
    // every pixel reading 0; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPIX; i++)
                mem[i] <= '0;
        end else if (pix_we) begin
            for (int c = 0; c < CH; c++)
                if (pix_mask[c])
                    mem[pix_addr][c*DATA_W +: DATA_W] <= pix_wdata[c*DATA_W +: DATA_W];
        end
    end

    // ---------------- read port ----------------
    // A signed (N+1)-bit coordinate lies in 0..2**N-1 exactly when its sign
    // bit is clear, so the range check is just the two MSBs.
    assign rd_in_range = !rd_row[ROW_W] && !rd_col[COL_W];
    assign rd_addr     = {rd_row[ROW_W-1:0], rd_col[COL_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= (rd_en && rd_in_range) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_local_mem_pixel_buf.sv
// ---------------------------------------------------------------------------
// tb_local_mem_pixel_buf
// Self-checking bench: directed vector table, bulk load / clear / reset
// sequences, and random accesses checked against an array reference model.
// ---------------------------------------------------------------------------
module tb_local_mem_pixel_buf;

    localparam int DATA_W = 16;
    localparam int CH     = 3;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;
    localparam int CH_W   = 2;
    localparam int H      = 32;
    localparam int W      = 32;
    localparam int NBEATS = CH * H * W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en;
    logic [CH_W-1:0]      wr_ch;
    logic [ROW_W-1:0]     wr_row;
    logic [COL_W-1:0]     wr_col;
    logic [DATA_W-1:0]    wr_data;
    logic                 ld_start, ld_valid;
    logic [DATA_W-1:0]    ld_data;
    logic                 ld_ready, ld_done;
    logic                 clr_start, busy;
    logic                 rd_en;
    logic [ROW_W:0]       rd_row;
    logic [COL_W:0]       rd_col;
    logic                 rd_valid;
    logic [CH*DATA_W-1:0] rd_data;

    always #5 clk = ~clk;

    local_mem_pixel_buf dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .clr_start(clr_start), .busy(busy),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    // Reference model: plain 3-D array indexed [channel][row][col].
    logic [DATA_W-1:0] model [CH][H][W];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          do_wr;
        int          ch, row, col;
        logic [15:0] wdata;
        int          rrow, rcol;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < H; r++)
                for (int k = 0; k < W; k++)
                    model[c][r][k] = '0;
    endtask

    function automatic logic [47:0] model_pix(input int row, input int col);
        if (row < 0 || row >= H || col < 0 || col >= W)
            return '0;
        return {model[2][row][col], model[1][row][col], model[0][row][col]};
    endfunction

    // Issued in IDLE: bench applies the drop rule for channels >= CH.
    task automatic do_write(input int ch, input int row, input int col, input logic [15:0] d);
        logic [CH_W-1:0]  cv;
        logic [ROW_W-1:0] rv;
        logic [COL_W-1:0] kv;
        cv = ch[CH_W-1:0]; rv = row[ROW_W-1:0]; kv = col[COL_W-1:0];
        wr_en = 1'b1; wr_ch = cv; wr_row = rv; wr_col = kv; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (ch < CH) model[ch][row][col] = d;
    endtask

    task automatic do_read(input int row, input int col, output logic v, output logic [47:0] d);
        rd_en = 1'b1; rd_row = row[ROW_W:0]; rd_col = col[COL_W:0];
        tick();
        v = rd_valid; d = rd_data;
        rd_en = 1'b0;
    endtask

    // Bulk load with random valid gaps. abort_at >= 0 asserts rst once that
    // many beats have been accepted.
    task automatic do_load(input int abort_at, input bit poke_write);
        int beats, cycles, early_done, c, r, k;
        bit poked;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("load_busy", busy, 1);
        check("load_ready", ld_ready, 1);
        beats = 0; cycles = 0; early_done = 0; poked = 0;
        while (beats < NBEATS && cycles < 20000) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = beats[15:0];
            if (poke_write && !poked && beats >= 500) begin
                poked = 1;
                wr_en = 1'b1; wr_ch = 0; wr_row = 1; wr_col = 2; wr_data = 16'hDEAD;
            end
            tick();
            cycles++;
            wr_en = 1'b0;
            if (ld_valid) begin
                c = beats / (H * W); r = (beats / W) % H; k = beats % W;
                model[c][r][k] = beats[15:0];
                beats++;
            end
            if (beats < NBEATS && ld_done) early_done++;
            if (abort_at >= 0 && beats == abort_at) begin
                ld_valid = 1'b0;
                rst = 1'b1;
                #1;
                check("abort_busy", busy, 0);
                check("abort_ld_ready", ld_ready, 0);
                check("abort_ld_done", ld_done, 0);
                model_zero();
                rst = 1'b0;
                tick();
                return;
            end
        end
        ld_valid = 1'b0;
        if (beats < NBEATS) check("load_timeout", beats, NBEATS);
        check("ld_done_pulse", ld_done, 1);
        check("ld_done_early", early_done, 0);
        tick();
        check("ld_done_once", ld_done, 0);
        check("load_idle_busy", busy, 0);
        check("load_idle_ready", ld_ready, 0);
    endtask

    initial begin
        logic        v;
        logic [47:0] d, e;
        int          row, col, busy_cycles, p, k;
        bit          pend;

        rst = 1'b1;
        wr_en = 0; wr_ch = 0; wr_row = 0; wr_col = 0; wr_data = 0;
        ld_start = 0; ld_valid = 0; ld_data = 0;
        clr_start = 0; rd_en = 0; rd_row = 0; rd_col = 0;
        model_zero();
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_ld_done", ld_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();

        // ---- directed vector table ----
        vecs[0] = '{0, 0, 0,  0, 16'h0000,  0,  0, 48'h0};
        vecs[1] = '{1, 1, 3,  7, 16'hABCD,  3,  7, 48'h0000_ABCD_0000};
        vecs[2] = '{1, 0, 3,  7, 16'h1111,  3,  7, 48'h0000_ABCD_1111};
        vecs[3] = '{0, 0, 0,  0, 16'h0000, -1,  5, 48'h0};
        vecs[4] = '{0, 0, 0,  0, 16'h0000, 32,  0, 48'h0};
        vecs[5] = '{0, 0, 0,  0, 16'h0000,  4, 32, 48'h0};
        vecs[6] = '{1, 3, 3,  7, 16'hFFFF,  3,  7, 48'h0000_ABCD_1111};
        vecs[7] = '{1, 2, 31, 31, 16'hBEEF, 31, 31, 48'hBEEF_0000_0000};
        vecs[8] = '{0, 0, 0,  0, 16'h0000, 31, -1, 48'h0};
        vecs[9] = '{1, 2, 3,  7, 16'h2222,  3,  7, 48'h2222_ABCD_1111};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) do_write(vecs[i].ch, vecs[i].row, vecs[i].col, vecs[i].wdata);
            do_read(vecs[i].rrow, vecs[i].rcol, v, d);
            check($sformatf("vec%0d_valid", i), v, 1);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp);
        end
        tick();
        check("idle_rd_valid", rd_valid, 0);
        check("idle_rd_data", rd_data, 0);

        // ---- bulk load with an ignored write mid-stream ----
        do_load(-1, 1);
        do_read(1, 2, v, d);
        check("load_pix_1_2", d, 48'h0822_0422_0022);
        check("load_pix_1_2_model", d, model_pix(1, 2));

        // ---- random accesses against the model ----
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write($urandom_range(0, 3), $urandom_range(0, H - 1),
                         $urandom_range(0, W - 1), 16'($urandom));
            end else begin
                row = int'($urandom_range(0, H + 1)) - 1;
                col = int'($urandom_range(0, W + 1)) - 1;
                do_read(row, col, v, d);
                check($sformatf("rand_rd(%0d,%0d)", row, col), {v, d}, {1'b1, model_pix(row, col)});
            end
        end

        // ---- clear (wins over a simultaneous load) with reads in flight ----
        clr_start = 1'b1; ld_start = 1'b1;
        tick();
        clr_start = 1'b0; ld_start = 1'b0;
        check("clear_busy", busy, 1);
        check("clear_wins", ld_ready, 0);
        busy_cycles = 1;
        while (busy && busy_cycles < 5000) begin
            pend = ($urandom_range(0, 7) == 0);
            if (pend) begin
                p = $urandom_range(0, H * W - 1);
                k = busy_cycles;
                // Pixel p is zeroed on clear edge p+1; a read on an edge sees pre-edge data.
                e = (p + 1 < k) ? 48'h0 : model_pix(p / W, p % W);
                rd_en = 1'b1; rd_row = 6'(p / W); rd_col = 6'(p % W);
            end
            tick();
            rd_en = 1'b0;
            if (pend) check($sformatf("clr_rd_p%0d_k%0d", p, k), rd_data, e);
            if (busy) busy_cycles++;
        end
        check("clear_cycles", busy_cycles, H * W);
        model_zero();
        for (int i = 0; i < 16; i++) begin
            row = $urandom_range(0, H - 1);
            col = $urandom_range(0, W - 1);
            do_read(row, col, v, d);
            check($sformatf("post_clr(%0d,%0d)", row, col), {v, d}, {1'b1, 48'h0});
        end

        // ---- reset in the middle of a load, then a clean reload ----
        do_write(1, 0, 0, 16'h5A5A);
        do_load(100, 0);
        do_read(0, 0, v, d);
        check("abort_rd_0_0", d, 48'h0);
        do_read(10, 10, v, d);
        check("abort_rd_10_10", d, model_pix(10, 10));
        do_load(-1, 0);
        do_read(1, 2, v, d);
        check("reload_pix_1_2", d, 48'h0822_0422_0022);
        do_read(31, 31, v, d);
        check("reload_pix_31_31", d, 48'h0BFF_07FF_03FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/local_mem_pixel_buf.md
Name: local_mem_pixel_buf

Overview:
- Parametrised on-chip pixel buffer for the convolution front end.
- Stores an H x W image of CH channels, DATA_W bits per sample.
- Supports single-sample writes and a streaming bulk loader with valid/ready handshake.
- Provides a hardware clear sequence, and a registered all-channel read that returns zero padding for out-of-range coordinates so the conv window needs no border logic.

Parameters:
- DATA_W, 16, bits per channel sample
- CH, 3, channel count (ch0 = red, ch1 = green, ch2 = blue)
- ROW_W, 5, row address bits; H = 2**ROW_W
- COL_W, 5, column address bits; W = 2**COL_W
- CH_W, $clog2(CH) min 1, derived localparam, channel index width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wr_en  in  1  single-sample write strobe
- wr_ch  in  CH_W  target channel
- wr_row  in  ROW_W  target row
- wr_col  in  COL_W  target column
- wr_data  in  DATA_W  write sample
- ld_start  in  1  begin bulk load
- ld_valid  in  1  load beat valid
- ld_data  in  DATA_W  load beat sample
- ld_ready  out  1  loader accepts beat
- ld_done  out  1  one-cycle pulse, load complete
- clr_start  in  1  begin clear
- busy  out  1  LOAD or CLEAR in progress
- rd_en  in  1  read request
- rd_row  in  ROW_W+1  signed read row; -1 and H are legal padding rows
- rd_col  in  COL_W+1  signed read column; same padding rule
- rd_valid  out  1  read data valid
- rd_data  out  CH*DATA_W  all channels; ch0 in bits [DATA_W-1:0], ascending

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values:
  - all storage is 0
  - state is IDLE
  - ld_ready, ld_done, busy and rd_valid are 0
  - rd_data is 0
  - load counters are 0
- FSM states: IDLE, LOAD, CLEAR.
- IDLE:
  - clr_start moves to CLEAR.
  - Otherwise ld_start moves to LOAD.
  - If both are asserted in the same cycle, clear wins.
- LOAD:
  - ld_ready = 1.
  - Each cycle with ld_valid & ld_ready writes ld_data to (ch, row, col) from the counter.
  - Beat order is channel-planar raster: col fastest, then row, then channel.
  - Total beats = CH*H*W.
  - Bubbles on ld_valid stall the counter.
  - On the last accepted beat: next state is IDLE and ld_done pulses high for exactly one cycle (the cycle after that beat).
- CLEAR:
  - Writes 0 to all CH channels of one pixel per cycle, raster order, H*W cycles.
  - Returns to IDLE after the last pixel; no done pulse.
- busy = (state != IDLE), registered.
- ld_start and clr_start are ignored while busy.
- wr_en:
  - Honoured only in IDLE; ignored while busy.
  - A write with wr_ch >= CH is dropped.
  - It writes only the addressed channel; the other channels of that pixel are unchanged.
- Read:
  - Latency is 1 cycle; rd_valid is rd_en delayed one cycle.
  - Reads are accepted in every state, including during LOAD and CLEAR.
  - If rd_row is outside 0..H-1 or rd_col is outside 0..W-1 (signed compare), rd_data = 0 with rd_valid = 1.
  - When rd_valid = 0, rd_data = 0.
  - Read and write to the same pixel in the same cycle: read returns the pre-write (old) value.
- Counter wrap:
  - Col wraps at W-1 into row+1.
  - Row wraps at H-1 into ch+1.
  - After the final beat the counters clear to 0.
- Reset mid-LOAD or mid-CLEAR: abort immediately; all storage and outputs take their reset values.

Decomposition:
- Package pixel_mem_pkg contains:
  - state enum typedef {IDLE, LOAD, CLEAR}
  - channel index constants CH_RED = 0, CH_GREEN = 1, CH_BLUE = 2
  - default DATA_W
- One sub-module, pixel_raster_cnt:
  - Parametrised ch/row/col counter with inc and clr inputs.
  - Provides a last-beat flag.
  - Shared by the LOAD and CLEAR paths; CLEAR uses only its row and col fields.

Test Plan:
- Reset -> read (0,0) -> one cycle later rd_valid = 1 and rd_data = 48'h0; busy = 0.
- Single write (red/ch0 to ch2):
  - wr_en, ch1, row 3, col 7, 16'hABCD, then read (3,7) -> rd_data = 48'h0000_ABCD_0000.
  - Then write ch0 = 16'h1111 -> read gives 48'h0000_ABCD_1111.
- Padding:
  - Read (-1,5), (32,0) and (4,32) -> rd_valid = 1, rd_data = 0 each.
  - A write with wr_ch = 3 is dropped; memory is unchanged.
- Bulk load:
  - ld_start, 3072 beats with data = beat index and random ld_valid gaps.
  - ld_done pulses once, 1 cycle after beat 3071.
  - Read (1,2) -> ch0 = 34, ch1 = 1058, ch2 = 2082.
  - wr_en during the load is ignored.
- Clear:
  - clr_start together with ld_start -> CLEAR is entered and busy is high for 1024 cycles.
  - Afterwards every sampled read returns 0.
  - A read issued during the clear returns either the old or the zeroed value, per raster position.
- Reset during load: assert rst at beat 100 -> busy = 0, ld_ready = 0 and ld_done = 0 immediately; read (0,0) = 0; a new load then completes normally.
